// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter.
//   MEM_DW / MEM_AW / MEM_DEPTH : default data width, address width and
//                                 number of valid memory words
//   REQ0 / REQ1                 : requester ids carried through the pipeline
//   tag_t                       : in-flight operation tag {valid, wr, id, err}
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int MEM_DW    = 8;
    localparam int MEM_AW    = 4;
    localparam int MEM_DEPTH = 11;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic wr;
        logic id;
        logic err;
    } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic with its priority pointer.
//   clk, reset_n        : clock, synchronous active-low reset
//   i_valid0, i_valid1  : request valids
//   o_grant0, o_grant1  : one-hot (or zero) grants, only with matching valid
//   o_grantId           : id of the granted requester (REQ0 when none)
// ---------------------------------------------------------------------------
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_grant0,
    output logic o_grant1,
    output logic o_grantId
);

    logic r_last;
    logic w_grant0;
    logic w_grant1;

    // On a tie the requester that was not served last wins; grants are
    // suppressed entirely while reset is held.
    always_comb begin
        w_grant0 = reset_n & i_valid0 & (~i_valid1 | (r_last == REQ1));
        w_grant1 = reset_n & i_valid1 & (~i_valid0 | (r_last == REQ0));
    end

    assign o_grant0  = w_grant0;
    assign o_grant1  = w_grant1;
    assign o_grantId = w_grant1 ? REQ1 : REQ0;

    // The pointer remembers who was served last. Resetting it to REQ1 makes
    // requester 0 win the first tie after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last <= REQ1;
        end else if (w_grant0 | w_grant1) begin
            r_last <= o_grantId;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter and sequencer in front of a single-port synchronous
// memory. Accepts one request per cycle from two requesters, issues a
// registered memory command, and returns a response two cycles after the
// handshake to the requester that issued it.
//   clk, reset_n                           : clock, sync active-low reset
//   reqN_valid/wr/add/wdata, reqN_ready    : request handshake, N = 0, 1
//   rspN_valid/rdata/err                   : one-cycle response, N = 0, 1
//   mem_enable/wrt_read/add/write          : registered memory command
//   mem_out                                : registered memory read data
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW    = MEM_DW,
    parameter int AW    = MEM_AW,
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          req0_valid,
    input  logic          req0_wr,
    input  logic [AW-1:0] req0_add,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp0_err,

    input  logic          req1_valid,
    input  logic          req1_wr,
    input  logic [AW-1:0] req1_add,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          rsp1_err,

    output logic          mem_enable,
    output logic          mem_wrt_read,
    output logic [AW-1:0] mem_add,
    output logic [DW-1:0] mem_write,
    input  logic [DW-1:0] mem_out
);

    // One extra bit so a DEPTH equal to 2**AW still compares correctly.
    localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

    logic          w_grant0;
    logic          w_grant1;
    logic          w_grantId;
    logic          w_handshake;
    logic          w_selWr;
    logic [AW-1:0] w_selAdd;
    logic [DW-1:0] w_selWdata;
    logic          w_selErr;
    logic [DW-1:0] w_rspData;

    logic          r_memEnable;
    logic          r_memWrtRead;
    logic [AW-1:0] r_memAdd;
    logic [DW-1:0] r_memWrite;
    tag_t          r_tag1;
    tag_t          r_tag2;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid0  (req0_valid),
        .i_valid1  (req1_valid),
        .o_grant0  (w_grant0),
        .o_grant1  (w_grant1),
        .o_grantId (w_grantId)
    );

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign w_handshake = w_grant0 | w_grant1;

    // Pick the fields of whichever requester won this cycle and flag an
    // out-of-range address so it can be kept off the memory port.
    always_comb begin
        w_selWr    = (w_grantId == REQ1) ? req1_wr    : req0_wr;
        w_selAdd   = (w_grantId == REQ1) ? req1_add   : req0_add;
        w_selWdata = (w_grantId == REQ1) ? req1_wdata : req0_wdata;
        w_selErr   = ({1'b0, w_selAdd} >= L_DEPTH);
    end

    // Command register: the strobe lasts exactly one cycle per in-range
    // handshake, while address/data only change on a handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_memEnable  <= 1'b0;
            r_memWrtRead <= 1'b0;
            r_memAdd     <= '0;
            r_memWrite   <= '0;
        end else begin
            r_memEnable <= w_handshake & ~w_selErr;
            if (w_handshake) begin
                r_memWrtRead <= w_selWr;
                r_memAdd     <= w_selAdd;
                r_memWrite   <= w_selWdata;
            end
        end
    end

    assign mem_enable   = r_memEnable;
    assign mem_wrt_read = r_memWrtRead;
    assign mem_add      = r_memAdd;
    assign mem_write    = r_memWrite;

    // Two-stage tag pipeline: stage 2 lines up with the cycle in which the
    // memory's registered output holds the result of the stage-1 command.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tag1 <= '0;
            r_tag2 <= '0;
        end else begin
            r_tag1 <= '{valid: w_handshake, wr: w_selWr, id: w_grantId, err: w_selErr};
            r_tag2 <= r_tag1;
        end
    end

    // Response demux: read data passes straight through from the memory,
    // and only the requester named in the tag sees anything.
    always_comb begin
        rsp0_valid = 1'b0;
        rsp0_err   = 1'b0;
        rsp0_rdata = '0;
        rsp1_valid = 1'b0;
        rsp1_err   = 1'b0;
        rsp1_rdata = '0;
        w_rspData  = (~r_tag2.wr & ~r_tag2.err) ? mem_out : '0;
        if (reset_n && r_tag2.valid) begin
            if (r_tag2.id == REQ0) begin
                rsp0_valid = 1'b1;
                rsp0_err   = r_tag2.err;
                rsp0_rdata = w_rspData;
            end else begin
                rsp1_valid = 1'b1;
                rsp1_err   = r_tag2.err;
                rsp1_rdata = w_rspData;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Drives two requesters against mem_arbiter with a behavioural memory
// attached. An independent arbitration/memory model predicts each grant and
// pushes the expected command and response into queues that are popped when
// they fall due.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 11;

    typedef struct {
        logic          wr;
        logic [AW-1:0] add;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        int            due;
        logic          id;
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    typedef struct {
        int            due;
        logic          wr;
        logic [AW-1:0] add;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic          clk;
    logic          resetN;
    logic          req0Valid, req0Wr, req0Ready, rsp0Valid, rsp0Err;
    logic [AW-1:0] req0Add;
    logic [DW-1:0] req0Wdata, rsp0Rdata;
    logic          req1Valid, req1Wr, req1Ready, rsp1Valid, rsp1Err;
    logic [AW-1:0] req1Add;
    logic [DW-1:0] req1Wdata, rsp1Rdata;
    logic          memEnable, memWrtRead;
    logic [AW-1:0] memAdd;
    logic [DW-1:0] memWrite, memOut;

    logic [DW-1:0] memArr [0:15];
    logic [DW-1:0] refMem [0:15];

    req_t pend0[$];
    req_t pend1[$];
    rsp_t rspQ[$];
    cmd_t cmdQ[$];

    int   cycle;
    int   totalChecks;
    int   badChecks;
    logic modelLast;

    mem_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (resetN),
        .req0_valid   (req0Valid),
        .req0_wr      (req0Wr),
        .req0_add     (req0Add),
        .req0_wdata   (req0Wdata),
        .req0_ready   (req0Ready),
        .rsp0_valid   (rsp0Valid),
        .rsp0_rdata   (rsp0Rdata),
        .rsp0_err     (rsp0Err),
        .req1_valid   (req1Valid),
        .req1_wr      (req1Wr),
        .req1_add     (req1Add),
        .req1_wdata   (req1Wdata),
        .req1_ready   (req1Ready),
        .rsp1_valid   (rsp1Valid),
        .rsp1_rdata   (rsp1Rdata),
        .rsp1_err     (rsp1Err),
        .mem_enable   (memEnable),
        .mem_wrt_read (memWrtRead),
        .mem_add      (memAdd),
        .mem_write    (memWrite),
        .mem_out      (memOut)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory with registered read data. It is
    // cleared on reset so the reference copy can track it exactly.
    always @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < 16; i++) memArr[i] <= '0;
            memOut <= '0;
        end else if (memEnable) begin
            if (memWrtRead) memArr[memAdd] <= memWrite;
            else            memOut <= memArr[memAdd];
        end
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s (cycle %0d): actual=0x%0h required=0x%0h", tag, cycle, act, exp);
        end
    endtask

    // Present the head of each requester's pending queue; valid holds until
    // the model says the request was accepted.
    task automatic applyStimulus();
        req0Valid = (pend0.size() > 0);
        req0Wr    = req0Valid ? pend0[0].wr    : 1'b0;
        req0Add   = req0Valid ? pend0[0].add   : '0;
        req0Wdata = req0Valid ? pend0[0].wdata : '0;
        req1Valid = (pend1.size() > 0);
        req1Wr    = req1Valid ? pend1[0].wr    : 1'b0;
        req1Add   = req1Valid ? pend1[0].add   : '0;
        req1Wdata = req1Valid ? pend1[0].wdata : '0;
    endtask

    // Compare everything the DUT shows in this cycle, then advance the model
    // for whatever handshake it predicts.
    task automatic sampleAndCheck();
        logic  expReady0, expReady1, rspDue, cmdDue, id, err;
        rsp_t  r;
        cmd_t  c;
        req_t  q;
        logic [DW-1:0] rd;

        expReady0 = resetN & req0Valid & (~req1Valid | modelLast);
        expReady1 = resetN & req1Valid & (~req0Valid | ~modelLast);
        checkOutput("ready0", 32'(req0Ready), 32'(expReady0));
        checkOutput("ready1", 32'(req1Ready), 32'(expReady1));

        rspDue = (rspQ.size() > 0) && (rspQ[0].due == cycle);
        r = '{due: 0, id: 1'b0, err: 1'b0, rdata: '0};
        if (rspDue) r = rspQ.pop_front();
        checkOutput("rsp0_valid", 32'(rsp0Valid), 32'(rspDue & (r.id == 1'b0)));
        checkOutput("rsp1_valid", 32'(rsp1Valid), 32'(rspDue & (r.id == 1'b1)));
        checkOutput("rsp0_rdata", 32'(rsp0Rdata), (rspDue && r.id == 1'b0) ? 32'(r.rdata) : 32'd0);
        checkOutput("rsp1_rdata", 32'(rsp1Rdata), (rspDue && r.id == 1'b1) ? 32'(r.rdata) : 32'd0);
        if (rspDue && r.id == 1'b0) checkOutput("rsp0_err", 32'(rsp0Err), 32'(r.err));
        if (rspDue && r.id == 1'b1) checkOutput("rsp1_err", 32'(rsp1Err), 32'(r.err));

        cmdDue = (cmdQ.size() > 0) && (cmdQ[0].due == cycle);
        checkOutput("mem_enable", 32'(memEnable), 32'(cmdDue));
        if (cmdDue) begin
            c = cmdQ.pop_front();
            checkOutput("mem_wrt_read", 32'(memWrtRead), 32'(c.wr));
            checkOutput("mem_add", 32'(memAdd), 32'(c.add));
            if (c.wr) checkOutput("mem_write", 32'(memWrite), 32'(c.wdata));
        end

        if (expReady0 | expReady1) begin
            id  = expReady1;
            q   = id ? pend1.pop_front() : pend0.pop_front();
            err = (32'(q.add) >= DEPTH);
            rd  = (!q.wr && !err) ? refMem[q.add] : '0;
            if (q.wr && !err) refMem[q.add] = q.wdata;
            rspQ.push_back('{due: cycle + 2, id: id, err: err, rdata: rd});
            if (!err) cmdQ.push_back('{due: cycle + 1, wr: q.wr, add: q.add, wdata: q.wdata});
            modelLast = id;
        end
    endtask

    // One clock cycle: reset bookkeeping at the edge, drive shortly after,
    // check on the falling edge.
    task automatic stepCycle();
        @(posedge clk);
        cycle++;
        if (!resetN) begin
            rspQ.delete();
            cmdQ.delete();
            modelLast = 1'b1;
            for (int i = 0; i < 16; i++) refMem[i] = '0;
        end
        #1;
        applyStimulus();
        @(negedge clk);
        sampleAndCheck();
    endtask

    // Run until all requests are accepted and all expectations retired.
    task automatic drain();
        int left;
        for (int i = 0; i < 40; i++) begin
            if (pend0.size() == 0 && pend1.size() == 0 && rspQ.size() == 0 && cmdQ.size() == 0) break;
            stepCycle();
        end
        left = pend0.size() + pend1.size() + rspQ.size() + cmdQ.size();
        checkOutput("drain", 32'(left), 32'd0);
    endtask

    function automatic req_t mkReq(input logic wr, input logic [AW-1:0] add, input logic [DW-1:0] wdata);
        req_t q;
        q.wr    = wr;
        q.add   = add;
        q.wdata = wdata;
        return q;
    endfunction

    initial begin
        cycle       = 0;
        totalChecks = 0;
        badChecks   = 0;
        modelLast   = 1'b1;
        for (int i = 0; i < 16; i++) refMem[i] = '0;
        resetN = 1'b0;
        applyStimulus();

        // Reset state.
        stepCycle();
        stepCycle();
        resetN = 1'b1;

        // Both requesters contend right after reset: grants alternate 0,1,0,1.
        pend0.push_back(mkReq(1'b1, 4'd1, 8'h11));
        pend0.push_back(mkReq(1'b0, 4'd1, 8'h00));
        pend1.push_back(mkReq(1'b1, 4'd2, 8'h22));
        pend1.push_back(mkReq(1'b0, 4'd2, 8'h00));
        drain();

        // Requester 0 writes 0x5A to address 3.
        pend0.push_back(mkReq(1'b1, 4'd3, 8'h5A));
        drain();

        // Write then read of the same address on consecutive cycles.
        pend0.push_back(mkReq(1'b1, 4'd3, 8'hC3));
        stepCycle();
        pend1.push_back(mkReq(1'b0, 4'd3, 8'h00));
        drain();

        // Address boundaries: 12 and 11 are out of range, 10 is the last word.
        pend0.push_back(mkReq(1'b0, 4'd12, 8'h00));
        pend1.push_back(mkReq(1'b1, 4'd11, 8'hEE));
        pend0.push_back(mkReq(1'b1, 4'd10, 8'hA5));
        pend0.push_back(mkReq(1'b0, 4'd10, 8'h00));
        drain();

        // Requester 1 streams three reads alone.
        pend1.push_back(mkReq(1'b0, 4'd3, 8'h00));
        pend1.push_back(mkReq(1'b0, 4'd10, 8'h00));
        pend1.push_back(mkReq(1'b0, 4'd2, 8'h00));
        drain();

        // Random mixed traffic.
        for (int i = 0; i < 40; i++) begin
            if (pend0.size() < 2 && $urandom_range(0, 1) == 1)
                pend0.push_back(mkReq(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
            if (pend1.size() < 2 && $urandom_range(0, 1) == 1)
                pend1.push_back(mkReq(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
            stepCycle();
        end
        drain();

        // Reset lands on the edge right after a handshake: nothing comes out.
        pend0.push_back(mkReq(1'b1, 4'd5, 8'h77));
        stepCycle();
        resetN = 1'b0;
        stepCycle();
        resetN = 1'b1;
        stepCycle();
        stepCycle();

        // First tie after reset goes to requester 0.
        pend0.push_back(mkReq(1'b0, 4'd5, 8'h00));
        pend1.push_back(mkReq(1'b0, 4'd5, 8'h00));
        drain();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
